// File: rtl/uart_tx_buffered.sv
`default_nettype none
// uart_tx_buffered: valid/ready byte stream -> synchronous FIFO -> 8N1 UART transmitter.
// Rev 1.0

module uart_tx_buffered #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                             clk_a,
   input  logic                             rst,
   input  logic [7:0]                       data_in,
   input  logic                             valid_in,
   output logic                             ready_in,
   output logic                             tx,
   output logic                             busy,
   output logic                             overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;

   logic              full;
   logic              push;
   logic              pop;

   // Full is judged on the registered count only, so a same-cycle pop never frees room for a push.
   assign full = (count_q == CNT_FULL);
   assign push = valid_in && !full;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (valid_in && full) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_a) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   always_ff @(posedge clk_a) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  // Bit 0 of the shifter is always the bit currently on the line.
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_a) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx         = tx_q;
   assign ready_in   = !full;
   assign busy       = (state_q != S_IDLE) || (count_q != '0);
   assign overflow   = overflow_q;
   assign fifo_count = count_q;

endmodule

`default_nettype wire
